// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: iterative CORDIC magnitude, gain correction,
// and a one-pole DC blocker producing signed audio.
module am_envelope_demod #(
    parameter int unsigned ITER     = 12,
    parameter int unsigned DC_SHIFT = 6
) (
    input  logic               CLK,
    input  logic               RSTb,
    input  logic               in_tick,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    input  logic               overrun_clr,
    output logic        [15:0] mag_out,
    output logic signed [15:0] audio_out,
    output logic               out_tick,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned XW   = 18;
    localparam int unsigned KW   = 5;
    localparam int unsigned ACCW = 17 + DC_SHIFT;
    localparam int unsigned DW   = 19;

    typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DCBLK} state_t;

    state_t                  state_q;
    logic signed [XW-1:0]    x_q;
    logic signed [XW-1:0]    y_q;
    logic        [KW-1:0]    k_q;
    logic        [15:0]      m_q;
    logic signed [ACCW-1:0]  dc_acc_q;

    logic signed [XW-1:0]    i_ext;
    logic signed [XW-1:0]    q_ext;
    logic signed [XW-1:0]    x_init;
    logic signed [XW-1:0]    y_init;
    logic signed [XW-1:0]    x_shr;
    logic signed [XW-1:0]    y_shr;
    logic signed [XW-1:0]    x_nxt;
    logic signed [XW-1:0]    y_nxt;
    logic signed [XW-1:0]    m_full;
    logic        [15:0]      m_sat;
    logic signed [16:0]      dc_avg;
    logic signed [DW-1:0]    dc_diff;
    logic        [DW-16:0]   diff_hi;
    logic signed [15:0]      audio_sat;
    logic signed [ACCW-1:0]  dc_acc_nxt;

    // Pre-rotate the input into the right half-plane without changing magnitude
    always_comb begin
        i_ext  = {{(XW-16){i_in[15]}}, i_in};
        q_ext  = {{(XW-16){q_in[15]}}, q_in};
        x_init = i_in[15] ? -i_ext : i_ext;
        y_init = i_in[15] ? -q_ext : q_ext;
    end

    // One CORDIC vectoring micro-rotation driving y toward zero
    always_comb begin
        x_shr = x_q >>> k_q;
        y_shr = y_q >>> k_q;
        if (!y_q[XW-1]) begin
            x_nxt = x_q + y_shr;
            y_nxt = y_q - x_shr;
        end else begin
            x_nxt = x_q - y_shr;
            y_nxt = y_q + x_shr;
        end
    end

    // Remove CORDIC gain (x * ~0.6074) and clamp into the unsigned 16-bit range
    always_comb begin
        m_full = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
        if (m_full[XW-1]) begin
            m_sat = 16'd0;
        end else if (|m_full[XW-2:16]) begin
            m_sat = 16'hFFFF;
        end else begin
            m_sat = m_full[15:0];
        end
    end

    // DC blocker: subtract the running average and saturate the audio sample
    always_comb begin
        dc_avg     = $signed(dc_acc_q[ACCW-1:DC_SHIFT]);
        dc_diff    = $signed({3'b000, m_q}) - $signed({{(DW-17){dc_avg[16]}}, dc_avg});
        diff_hi    = dc_diff[DW-1:15];
        if (diff_hi == '0 || diff_hi == '1) begin
            audio_sat = dc_diff[15:0];
        end else begin
            audio_sat = dc_diff[DW-1] ? 16'sh8000 : 16'sh7FFF;
        end
        dc_acc_nxt = dc_acc_q + ACCW'(dc_diff);
    end

    // Sequencer: load, iterate, scale, DC-block; registers all outputs
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            dc_acc_q  <= '0;
            mag_out   <= '0;
            audio_out <= '0;
            out_tick  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_tick <= 1'b0;
            if (in_tick && state_q != IDLE) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (in_tick) begin
                        x_q     <= x_init;
                        y_q     <= y_init;
                        k_q     <= '0;
                        busy    <= 1'b1;
                        state_q <= ROTATE;
                    end
                end
                ROTATE: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    k_q <= k_q + KW'(1);
                    if (k_q == KW'(ITER - 1)) begin
                        state_q <= SCALE;
                    end
                end
                SCALE: begin
                    m_q     <= m_sat;
                    state_q <= DCBLK;
                end
                DCBLK: begin
                    audio_out <= audio_sat;
                    dc_acc_q  <= dc_acc_nxt;
                    mag_out   <= m_q;
                    out_tick  <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
